// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch PC generator.
// Holds the B-type opcode, the 2-bit counter encodings and the saturating update helper.
package if_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t CNT_SNT = 2'b00;
    localparam bht_cnt_t CNT_WNT = 2'b01;
    localparam bht_cnt_t CNT_WT  = 2'b10;
    localparam bht_cnt_t CNT_ST  = 2'b11;
    localparam bht_cnt_t CNT_RST = CNT_WNT;

    function automatic bht_cnt_t cnt_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t res;
        res = cnt;
        if (taken && (cnt != CNT_ST)) begin
            res = cnt + 2'd1;
        end else if (!taken && (cnt != CNT_SNT)) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/if_bht.sv
// Bimodal branch history table: 2-bit saturating counters, async read, sync write.
// Only instantiated when IF_BHT_EN is defined.
module if_bht
    import if_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_cnt_t cnt [ENTRIES];

    // Read sees the pre-update value; a same-index write lands on the next edge.
    assign rd_pred = cnt[rd_idx][1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt[i] <= CNT_RST;
            end
        end else if (wr_en) begin
            cnt[wr_idx] <= cnt_next(cnt[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: next-PC selection, predecode and branch prediction.
// Define IF_BHT_EN for the bimodal BHT; otherwise backward-taken/forward-not-taken.
module if_pc_gen
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_mem_read_data,
    output logic [31:0] inst_mem_read_addr,
    output logic        IF_take,
    input  logic        EX_stall,
    input  logic        ID_branch,
    input  logic [31:0] ID_jump_target,
    input  logic        EX_branch,
    input  logic        EX_zero,
    input  logic        EX_pred,
    input  logic [31:0] EX_pc_plus4,
    input  logic [31:0] EX_target
);

    if (BHT_ENTRIES < 2 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_cfg
        $error("if_pc_gen: BHT_ENTRIES must be a power of 2 and at least 2");
    end

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] imm_b;
    logic [31:0] pred_target;
    logic        is_br;
    logic        pred_bit;
    logic        mispred;
    logic        unused_bits;

    assign is_br = (inst_mem_read_data[6:0] == OPC_BRANCH);
    assign imm_b = {{19{inst_mem_read_data[31]}}, inst_mem_read_data[31], inst_mem_read_data[7],
                    inst_mem_read_data[30:25], inst_mem_read_data[11:8], 1'b0};
    assign pred_target = pc + imm_b;
    assign unused_bits = ^inst_mem_read_data[24:12];

    assign IF_take = is_br && pred_bit && reset;
    assign mispred = EX_branch && (EX_zero != EX_pred);
    assign inst_mem_read_addr = pc;

`ifdef IF_BHT_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             bht_we;

    assign rd_idx = pc[IDX_W+1:2];
    // (pc+4)-4 only touches bits [31:2], so the index is the pc+4 index minus one.
    assign wr_idx = EX_pc_plus4[IDX_W+1:2] - IDX_W'(1);
    assign bht_we = EX_branch && (!EX_stall || mispred);

    if_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_pred  (pred_bit),
        .wr_en    (bht_we),
        .wr_idx   (wr_idx),
        .wr_taken (EX_zero)
    );
`else
    assign pred_bit = imm_b[12];
`endif

    always_comb begin
        pc_next = pc + 32'd4;
        if (mispred) begin
            pc_next = EX_zero ? EX_target : EX_pc_plus4;
        end else if (EX_stall) begin
            pc_next = pc;
        end else if (ID_branch) begin
            pc_next = ID_jump_target;
        end else if (IF_take) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule
